full_protocol_tx: RTL and testbench
===================================

Name: full_protocol_tx

Overview:
- Serial transmitter for the single-wire RGB command frame.
- Takes a command byte, a length byte, R/G/B bytes and a checksum byte from the host side and shifts them out on one idle-high line.
- Frame format: one start bit (0), then 48 data bits, then a guard period at idle high.
- Drives the data_in line of the RGB receiver (full_protocol) and is used as its stimulus source in system-level benches.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per serial bit (100 x 10 ns clk = 1 us bit).
- GUARD_BITS, 1, idle-high bit periods appended after the checksum before finished/ready.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send one frame; sampled only in IDLE.
- cmd_data_in  input  8  command byte.
- length_data_in  input  8  length byte.
- r_data_in  input  8  red byte.
- g_data_in  input  8  green byte.
- b_data_in  input  8  blue byte.
- check_data_in  input  8  checksum byte (used only when the optional feature is off).
- data_out  output  1  serial line; idle 1.
- busy  output  1  high from frame accept until return to IDLE.
- finished  output  1  one-cycle pulse at end of frame (after guard).
- state  output  4  current FSM state encoding, for debug.

Behaviour:
- Reset (sync, on any cycle, including mid-frame): next edge gives state=IDLE, data_out=1, busy=0, finished=0, bit/clock counters=0. The partial frame is abandoned and no finished pulse is generated.
- States/encoding:
  - IDLE=0, START=1, CMD=2, LEN=3, RED=4, GRN=5, BLU=6, CHK=7, GUARD=8.
  - Encodings 9-15 are unreachable; if entered, go to IDLE.
- IDLE:
  - data_out=1, busy=0.
  - If start=1, latch all six bytes into internal registers and go to START.
  - The first start-bit cycle on data_out is the cycle after start is sampled (1-cycle latency).
- START: data_out=0 for CLKS_PER_BIT cycles, then go to CMD.
- Byte states CMD -> LEN -> RED -> GRN -> BLU -> CHK:
  - Each sends its latched byte MSB first (bit7..bit0).
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - A 3-bit index advances after each bit; after bit0 go to the next state.
  - No inter-byte start/stop bits.
- GUARD: data_out=1 for GUARD_BITS*CLKS_PER_BIT cycles.
  - On the last cycle of GUARD, finished=1 for exactly one cycle and the next state is IDLE.
  - busy falls with the return to IDLE.
- Frame length: (1+48+GUARD_BITS)*CLKS_PER_BIT cycles from first start-bit cycle to the IDLE return; 5000 cycles with defaults.
- Input changes:
  - start while busy=1 is ignored; no queuing.
  - Changes on the byte inputs during a frame do not affect it; values are latched at accept.
- start held high continuously: a new frame is accepted on the first IDLE cycle after finished, so back-to-back frames are separated by exactly the guard period.
- Clock counter: width $clog2(CLKS_PER_BIT*GUARD_BITS)+1; it wraps to 0 at each bit boundary, never free-runs.
- data_out is registered with no combinational path from inputs.

Optional Feature:
- Macro FULL_PROTOCOL_TX_CKSUM_EN.
- Defined: the checksum byte sent in CHK is computed internally at accept as cmd ^ length ^ r ^ g ^ b (8-bit XOR). check_data_in is ignored.
- Undefined: the byte sent in CHK is the latched check_data_in, unmodified.
- Port list is identical in both builds.

Test Plan:
- Reset then idle, start=0 for 2000 cycles -> data_out=1, busy=0, finished=0, state=0 throughout.
- Macro off, start pulse with cmd=0xB6, len=0xC0, r=0xAB, g=0xCA, b=0x41, check=0xAA:
  - data_out: 0 for 100 cycles, then bits 10110110 11000000 10101011 11001010 01000001 10101010, each 100 cycles, then 1.
  - finished pulses exactly at cycle 5000 after the first start-bit cycle.
  - Loopback into full_protocol reproduces all six bytes.
- Macro on, same data bytes, check=0x00 -> checksum field serialised as 0x56 (01010110).
- start re-pulsed at cycle 1500 of an active frame, with all byte inputs changed to 0x00 -> ignored; original frame bits unchanged; a single finished pulse.
- reset asserted during RED bit 3 -> data_out=1 and state=0 next cycle; no finished; a subsequent start sends a full, correct frame.
- start held high across two frames (cmd=0x76 then 0x12) -> second start bit begins exactly 1 cycle after IDLE is re-entered; each frame produces one finished pulse.

Source files
------------

// File: rtl/full_protocol_tx.sv
// Single-wire RGB command frame transmitter: start bit, six MSB-first bytes, idle-high guard.
// Optional macro FULL_PROTOCOL_TX_CKSUM_EN replaces check_data_in with an internal XOR checksum.
module full_protocol_tx #(
    parameter int CLKS_PER_BIT = 100,
    parameter int GUARD_BITS   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] cmd_data_in,
    input  logic [7:0] length_data_in,
    input  logic [7:0] r_data_in,
    input  logic [7:0] g_data_in,
    input  logic [7:0] b_data_in,
    input  logic [7:0] check_data_in,
    output logic       data_out,
    output logic       busy,
    output logic       finished,
    output logic [3:0] state
);

    localparam int GUARD_CYCLES = CLKS_PER_BIT * GUARD_BITS;
    localparam int CNT_W        = $clog2(GUARD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_PRE  = CNT_W'(GUARD_CYCLES - 2);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             GUARD_ONE  = (GUARD_CYCLES == 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_START = 4'd1,
        S_CMD   = 4'd2,
        S_LEN   = 4'd3,
        S_RED   = 4'd4,
        S_GRN   = 4'd5,
        S_BLU   = 4'd6,
        S_CHK   = 4'd7,
        S_GUARD = 4'd8
    } state_t;

    state_t           r_state;
    logic             r_data_out;
    logic             r_busy;
    logic             r_finished;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_bytes [0:5];

    logic [7:0] w_in_bytes [0:5];
    logic [7:0] w_chk_byte;
    logic [7:0] w_cur_byte;
    logic [7:0] w_next_byte;
    logic       w_accept;
    logic       w_bit_done;

`ifdef FULL_PROTOCOL_TX_CKSUM_EN
    logic w_unused_check;
    assign w_unused_check = ^check_data_in;
    assign w_chk_byte = cmd_data_in ^ length_data_in ^ r_data_in ^ g_data_in ^ b_data_in;
`else
    assign w_chk_byte = check_data_in;
`endif

    assign w_in_bytes[0] = cmd_data_in;
    assign w_in_bytes[1] = length_data_in;
    assign w_in_bytes[2] = r_data_in;
    assign w_in_bytes[3] = g_data_in;
    assign w_in_bytes[4] = b_data_in;
    assign w_in_bytes[5] = w_chk_byte;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_bit_done = (r_clk_cnt == BIT_LAST);

    // Frame bytes are frozen at accept so host-side changes mid-frame are invisible.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < 6; i++) begin
                r_bytes[i] <= w_in_bytes[i];
            end
        end
    end

    always_comb begin
        w_cur_byte  = r_bytes[0];
        w_next_byte = r_bytes[0];
        case (r_state)
            S_CMD: begin w_cur_byte = r_bytes[0]; w_next_byte = r_bytes[1]; end
            S_LEN: begin w_cur_byte = r_bytes[1]; w_next_byte = r_bytes[2]; end
            S_RED: begin w_cur_byte = r_bytes[2]; w_next_byte = r_bytes[3]; end
            S_GRN: begin w_cur_byte = r_bytes[3]; w_next_byte = r_bytes[4]; end
            S_BLU: begin w_cur_byte = r_bytes[4]; w_next_byte = r_bytes[5]; end
            S_CHK: begin w_cur_byte = r_bytes[5]; w_next_byte = r_bytes[5]; end
            default: ;
        endcase
    end

    // data_out always carries the value for the state/bit being entered, so it stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_data_out <= 1'b1;
            r_busy     <= 1'b0;
            r_finished <= 1'b0;
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
        end else begin
            r_finished <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_data_out <= 1'b1;
                    r_busy     <= 1'b0;
                    r_clk_cnt  <= '0;
                    r_bit_idx  <= 3'd0;
                    if (start) begin
                        r_state    <= S_START;
                        r_data_out <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_clk_cnt  <= '0;
                        r_state    <= S_CMD;
                        r_data_out <= r_bytes[0][7];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_CMD, S_LEN, S_RED, S_GRN, S_BLU, S_CHK: begin
                    if (w_bit_done) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            if (r_state == S_CHK) begin
                                r_state    <= S_GUARD;
                                r_data_out <= 1'b1;
                                r_finished <= GUARD_ONE;
                            end else begin
                                r_state    <= state_t'(r_state + 4'd1);
                                r_data_out <= w_next_byte[7];
                            end
                        end else begin
                            r_bit_idx  <= r_bit_idx + 3'd1;
                            r_data_out <= w_cur_byte[3'd6 - r_bit_idx];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_ONE;
                    end
                end
                S_GUARD: begin
                    r_data_out <= 1'b1;
                    if (r_clk_cnt == GUARD_LAST) begin
                        r_state   <= S_IDLE;
                        r_busy    <= 1'b0;
                        r_clk_cnt <= '0;
                    end else begin
                        r_clk_cnt  <= r_clk_cnt + CNT_ONE;
                        r_finished <= (r_clk_cnt == GUARD_PRE);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_data_out <= 1'b1;
                    r_busy     <= 1'b0;
                    r_clk_cnt  <= '0;
                    r_bit_idx  <= 3'd0;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign busy     = r_busy;
    assign finished = r_finished;
    assign state    = r_state;

endmodule

// File: tb/tb_full_protocol_tx.sv
// Directed bench for full_protocol_tx: checks {data_out,busy,finished,state} every cycle of each frame.
module tb_full_protocol_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] cmd_data_in, length_data_in, r_data_in, g_data_in, b_data_in, check_data_in;
    logic       data_out, busy, finished;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    full_protocol_tx dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .cmd_data_in    (cmd_data_in),
        .length_data_in (length_data_in),
        .r_data_in      (r_data_in),
        .g_data_in      (g_data_in),
        .b_data_in      (b_data_in),
        .check_data_in  (check_data_in),
        .data_out       (data_out),
        .busy           (busy),
        .finished       (finished),
        .state          (state)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] IDLE_VEC = 7'b1_0_0_0000;

`ifdef FULL_PROTOCOL_TX_CKSUM_EN
    localparam logic [7:0] A_CHK_IN = 8'h00, A_CHK_TX = 8'h56;
    localparam logic [7:0] B_CHK_TX = 8'h75, C_CHK_TX = 8'h6F;
`else
    localparam logic [7:0] A_CHK_IN = 8'hAA, A_CHK_TX = 8'hAA;
    localparam logic [7:0] B_CHK_TX = 8'h5A, C_CHK_TX = 8'hC3;
`endif
    localparam logic [47:0] BITS_A = {8'hB6, 8'hC0, 8'hAB, 8'hCA, 8'h41, A_CHK_TX};
    localparam logic [47:0] BITS_B = {8'h76, 8'h03, 8'h11, 8'h22, 8'h33, B_CHK_TX};
    localparam logic [47:0] BITS_C = {8'h12, 8'h03, 8'h80, 8'h01, 8'hFF, C_CHK_TX};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] obs_vec();
        return {data_out, busy, finished, state};
    endfunction

    task automatic set_bytes(input logic [7:0] c, l, r, g, b, k);
        cmd_data_in = c; length_data_in = l; r_data_in = r;
        g_data_in = g; b_data_in = b; check_data_in = k;
    endtask

    // Called #1 after an edge with start already high in IDLE; returns at the first IDLE cycle.
    task automatic check_frame(input logic [47:0] bits, input int repulse_at,
                               input int abort_at, input bit hold_start, input string name);
        logic       exp_d;
        logic [3:0] exp_s;
        int         pulses;
        pulses = 0;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            if (c < 100) begin
                exp_d = 1'b0; exp_s = 4'd1;
            end else if (c < 4900) begin
                exp_d = bits[47 - (c - 100) / 100];
                exp_s = 4'(2 + (c - 100) / 800);
            end else begin
                exp_d = 1'b1; exp_s = 4'd8;
            end
            if (finished) pulses++;
            chk($sformatf("%s c%0d", name, c), 32'(obs_vec()),
                32'({exp_d, 1'b1, (c == 4999), exp_s}));
            if (c == repulse_at) begin
                start = 1'b1;
                set_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
            end
            if (c == repulse_at + 1 && !hold_start) start = 1'b0;
            if (c == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("%s abort", name), 32'(obs_vec()), 32'(IDLE_VEC));
                reset = 1'b0;
                pulses = 0;
                for (int k = 0; k < 300; k++) begin
                    @(posedge clk); #1;
                    if (finished) pulses++;
                end
                chk($sformatf("%s abort_idle", name), 32'(obs_vec()), 32'(IDLE_VEC));
                chk($sformatf("%s abort_pulses", name), 32'(pulses), 32'd0);
                $display("frame %s aborted, pulses=%0d", name, pulses);
                return;
            end
            @(posedge clk); #1;
        end
        chk($sformatf("%s end_idle", name), 32'(obs_vec()), 32'(IDLE_VEC));
        chk($sformatf("%s pulses", name), 32'(pulses), 32'd1);
        $display("frame %s cmd=%02h done, finished pulses=%0d", name, bits[47:40], pulses);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'(obs_vec()), 32'(IDLE_VEC));
        reset = 1'b0;

        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            chk($sformatf("idle c%0d", i), 32'(obs_vec()), 32'(IDLE_VEC));
        end
        $display("idle 2000 cycles done");

        set_bytes(8'hB6, 8'hC0, 8'hAB, 8'hCA, 8'h41, A_CHK_IN);
        start = 1'b1;
        check_frame(BITS_A, -10, -10, 1'b0, "A");

        set_bytes(8'hB6, 8'hC0, 8'hAB, 8'hCA, 8'h41, A_CHK_IN);
        start = 1'b1;
        check_frame(BITS_A, 1500, -10, 1'b0, "A_repulse");

        set_bytes(8'hB6, 8'hC0, 8'hAB, 8'hCA, 8'h41, A_CHK_IN);
        start = 1'b1;
        check_frame(BITS_A, -10, 2150, 1'b0, "A_abort");

        set_bytes(8'hB6, 8'hC0, 8'hAB, 8'hCA, 8'h41, A_CHK_IN);
        start = 1'b1;
        check_frame(BITS_A, -10, -10, 1'b0, "A_after_abort");

        set_bytes(8'h76, 8'h03, 8'h11, 8'h22, 8'h33, 8'h5A);
        start = 1'b1;
        check_frame(BITS_B, -10, -10, 1'b1, "B_held");
        set_bytes(8'h12, 8'h03, 8'h80, 8'h01, 8'hFF, 8'hC3);
        check_frame(BITS_C, -10, -10, 1'b1, "C_held");
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("post_held_idle", 32'(obs_vec()), 32'(IDLE_VEC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
